// File: rtl/ysyx_210247_wb_sched_pkg.sv
// Shared constants and types for the writeback scheduler.
// Register-index width, bus width and the writeback source encoding.
package ysyx_210247_wb_sched_pkg;

  localparam int          REG_BUS   = 64;
  localparam int          REG_IDX_W = 5;
  localparam int          NUM_REGS  = 1 << REG_IDX_W;
  localparam logic [63:0] ZERO_WORD = 64'h0;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_e;

  function automatic logic [NUM_REGS-1:0] idx_mask(input logic [REG_IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ysyx_210247_wb_sched_if.sv
// Handshake bundle between execute/LSU/issue and the writeback scheduler.
// Forwarding signals exist only when YSYX_210247_WB_FWD_EN is defined.
interface ysyx_210247_wb_sched_if #(parameter int XLEN = 64);

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            iss_valid;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic            iss_rs1_en;
  logic            iss_rs2_en;
  logic [4:0]      iss_rd;
  logic            iss_rd_en;
  logic            iss_stall;

  logic            rf_w_ena;
  logic [4:0]      rf_w_addr;
  logic [XLEN-1:0] rf_w_data;
  logic [31:0]     busy_o;

`ifdef YSYX_210247_WB_FWD_EN
  logic            fwd1_hit;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd_data;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rs1, iss_rs2, iss_rs1_en, iss_rs2_en, iss_rd, iss_rd_en,
    input  alu_ready, lsu_ready, iss_stall,
    input  rf_w_ena, rf_w_addr, rf_w_data, busy_o
`ifdef YSYX_210247_WB_FWD_EN
    , input fwd1_hit, fwd2_hit, fwd_data
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rs1, iss_rs2, iss_rs1_en, iss_rs2_en, iss_rd, iss_rd_en,
    output alu_ready, lsu_ready, iss_stall,
    output rf_w_ena, rf_w_addr, rf_w_data, busy_o
`ifdef YSYX_210247_WB_FWD_EN
    , output fwd1_hit, fwd2_hit, fwd_data
`endif
  );

endinterface

// File: rtl/ysyx_210247_wb_sched_scoreboard.sv
// Busy-bit scoreboard: one bit per integer register, x0 never busy.
// A set and a clear of the same register in one cycle leaves it busy.
module ysyx_210247_scoreboard
  import ysyx_210247_wb_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    set_mask = set_en ? idx_mask(set_idx) : '0;
    clr_mask = clr_en ? idx_mask(clr_idx) : '0;
    // Set is applied after clear so the new producer keeps ownership.
    busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign rs1_busy = busy_q[rs1_idx];
  assign rs2_busy = busy_q[rs2_idx];
  assign rd_busy  = busy_q[rd_idx];

endmodule

// File: rtl/ysyx_210247_wb_sched.sv
// Writeback scheduler: LSU-over-ALU arbitration onto the single RF write port
// plus issue hazard detection. YSYX_210247_WB_FWD_EN adds a one-cycle forward path.
module ysyx_210247_wb_sched
  import ysyx_210247_wb_sched_pkg::*;
#(
  parameter int XLEN = REG_BUS
) (
  input logic                   clk,
  input logic                   rst_n,
  ysyx_210247_wb_sched_if.slave bus
);

  wb_src_e              src;
  logic                 issue;
  logic                 set_en;
  logic                 raw1;
  logic                 raw2;
  logic                 waw;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 rd_busy;
  logic [NUM_REGS-1:0]  busy;

  logic                 w_ena_q;
  logic [REG_IDX_W-1:0] w_addr_q;
  logic [XLEN-1:0]      w_data_q;

  // Ready is purely combinational so it keeps following valid during reset.
  assign bus.lsu_ready = 1'b1;
  assign bus.alu_ready = !bus.lsu_valid;

  always_comb begin
    src = WB_NONE;
    if (bus.lsu_valid)      src = WB_LSU;
    else if (bus.alu_valid) src = WB_ALU;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ena_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      case (src)
        WB_LSU: begin
          w_ena_q  <= (bus.lsu_rd != '0);
          w_addr_q <= bus.lsu_rd;
          w_data_q <= bus.lsu_data;
        end
        WB_ALU: begin
          w_ena_q  <= (bus.alu_rd != '0);
          w_addr_q <= bus.alu_rd;
          w_data_q <= bus.alu_data;
        end
        default: w_ena_q <= 1'b0;
      endcase
    end
  end

  assign bus.rf_w_ena  = w_ena_q;
  assign bus.rf_w_addr = w_addr_q;
  assign bus.rf_w_data = w_data_q;

`ifdef YSYX_210247_WB_FWD_EN
  logic fwd1;
  logic fwd2;
  assign fwd1         = w_ena_q & bus.iss_rs1_en & (w_addr_q == bus.iss_rs1);
  assign fwd2         = w_ena_q & bus.iss_rs2_en & (w_addr_q == bus.iss_rs2);
  assign bus.fwd1_hit = fwd1;
  assign bus.fwd2_hit = fwd2;
  assign bus.fwd_data = w_data_q;
  assign raw1         = bus.iss_rs1_en & rs1_busy & !fwd1;
  assign raw2         = bus.iss_rs2_en & rs2_busy & !fwd2;
`else
  assign raw1         = bus.iss_rs1_en & rs1_busy;
  assign raw2         = bus.iss_rs2_en & rs2_busy;
`endif

  assign waw           = bus.iss_rd_en & rd_busy;
  assign bus.iss_stall = bus.iss_valid & (raw1 | raw2 | waw);
  assign issue         = bus.iss_valid & !bus.iss_stall;
  assign set_en        = issue & bus.iss_rd_en & (bus.iss_rd != '0);

  ysyx_210247_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_idx  (bus.iss_rd),
    .clr_en   (w_ena_q),
    .clr_idx  (w_addr_q),
    .rs1_idx  (bus.iss_rs1),
    .rs2_idx  (bus.iss_rs2),
    .rd_idx   (bus.iss_rd),
    .busy     (busy),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  assign bus.busy_o = busy;

endmodule
